register_ro: RTL and testbench
==============================

Name: register_ro

Overview:
- Read-side counterpart of the writable config register (register_rw) in the HyperRAM controller register space.
- Collects hardware status/event bits (e.g. transfer done, latency error) into a sticky status register.
- Bus side reads it with a one-cycle request/acknowledge handshake and clear-on-read semantics.
- A maskable interrupt output is derived from the status bits.

Parameters:
- WIDTH, 32, width of the status register and read data.
- CLEAR_MASK, {WIDTH{1'b1}}, bits cleared by a read; 0-bits are level/sticky-until-reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- set_in  input  WIDTH  per-bit event pulses from the controller core; bit=1 sets the corresponding status bit.
- rden  input  1  read request, sampled each rising edge.
- mask_wren  input  1  write strobe for the interrupt mask.
- mask_in  input  WIDTH  new interrupt mask value.
- data_out  output  WIDTH  read data; valid while ack=1 and held until the next accepted read.
- ack  output  1  one-cycle read acknowledge.
- irq  output  1  registered interrupt: OR of (status & irq_mask).

Behaviour:
- Reset (rst=0, async):
  - status=0, irq_mask=0.
  - data_out=0, ack=0, irq=0; overrun=0 when the optional feature is built.
  - Reset mid-read drops a pending ack; no ack is produced after release.
- Status update each edge, with no read accepted: status <= status | set_in.
- Read accepted on an edge with rden=1:
  - data_out <= status | set_in, so same-cycle events are included in the snapshot.
  - ack <= 1.
  - status <= (status | set_in) & ~CLEAR_MASK.
- Latency: ack and data_out appear exactly 1 cycle after rden is sampled high.
- ack is high for one cycle per accepted rden.
- Back-to-back reads (rden high on consecutive edges) are all accepted. Each returns a fresh snapshot with an ack on every cycle; the second snapshot shows only events since the first (for bits in CLEAR_MASK).
- Bits outside CLEAR_MASK are never cleared except by reset.
- No event is lost: an event arriving on the read edge is reported in that read. An event arriving on any later edge is reported in the next read.
- mask_wren=1: irq_mask <= mask_in. The mask does not affect status or data_out.
- irq <= |(status_next & irq_mask_next), registered, where status_next and irq_mask_next are the values being loaded on the same edge.
  - irq falls in the cycle ack rises when a read clears all masked pending bits.
  - A simultaneous set on the read edge is cleared too, since it is reported in data_out.
- Simultaneous mask_wren and rden: both take effect on the same edge; irq is computed with the new mask and the post-clear status.
- rden is ignored while rst=0.

Optional Feature:
- Macro: REGISTER_RO_OVERRUN_EN.
- Defined:
  - Adds output port overrun (WIDTH).
  - Bit i sets when set_in[i]=1 while status[i] is already 1 and that bit is not being cleared on the same edge.
  - overrun is cleared together with status on a read: the same CLEAR_MASK bits, with snapshot semantics.
  - The value before clearing is presented on overrun alongside ack.
  - Resets to 0.
- Not defined: no overrun port or logic; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with set_in=32'hFFFF_FFFF, then release → data_out=0, ack=0, irq=0; the first read returns 32'hFFFF_FFFF only for events set after release.
- Sticky + clear-on-read: pulse set_in=32'h0000_0005 for 1 cycle, wait 3 cycles, rden=1 → next cycle ack=1, data_out=32'h5; a second read returns 32'h0.
- Same-edge event: set_in=32'h8000_0000 on the same edge as rden → data_out=32'h8000_0000; the following read returns 0.
- Back-to-back: rden high 3 cycles with set_in=32'h1, 32'h2, 32'h4 on those edges → acks on 3 consecutive cycles, data_out = 1, 2, 4.
- Interrupt: mask_in=32'h2 with mask_wren, then set_in=32'h1 → irq stays 0; then set_in=32'h2 → irq=1 the next cycle; read → irq=0 in the ack cycle.
- Overrun (REGISTER_RO_OVERRUN_EN): set_in=32'h1 twice without a read → overrun=32'h1; a read shows overrun=1 with ack, then 0.

Source files
------------

// File: rtl/register_ro.sv
// ---------------------------------------------------------------------------
// register_ro -- sticky status register with clear-on-read and maskable irq.
//
// Read side of the HyperRAM controller register space. Hardware events on
// set_in are accumulated into a sticky status register. A read (rden) returns
// a snapshot one cycle later with a single-cycle ack, and clears the bits
// selected by CLEAR_MASK. irq is the registered OR of status & irq_mask.
//
// Parameters:
//   WIDTH       width of status / read data
//   CLEAR_MASK  bits cleared by a read (0-bits are sticky until reset)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   set_in     per-bit event pulses (1 sets the status bit)
//   rden       read request, sampled every rising edge
//   mask_wren  interrupt mask write strobe
//   mask_in    new interrupt mask value
//   data_out   read snapshot, valid with ack, held until the next read
//   ack        one-cycle read acknowledge
//   irq        registered interrupt
//   overrun    (only with REGISTER_RO_OVERRUN_EN) per-bit event overrun flags;
//              shows the pre-clear snapshot during the ack cycle
//
// Optional feature macro: REGISTER_RO_OVERRUN_EN
// ---------------------------------------------------------------------------
module register_ro #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   CLEAR_MASK = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set_in,
    input  logic             rden,
    input  logic             mask_wren,
    input  logic [WIDTH-1:0] mask_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ack,
`ifdef REGISTER_RO_OVERRUN_EN
    output logic [WIDTH-1:0] overrun,
`endif
    output logic             irq
);

    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] clr_now;

    always_comb begin
        // Events landing on the read edge are folded into the snapshot, so
        // they can be cleared along with everything else without being lost.
        merged   = status_q | set_in;
        clr_now  = CLEAR_MASK & {WIDTH{rden}};
        status_d = merged & ~clr_now;
        mask_d   = mask_wren ? mask_in : mask_q;
        data_d   = rden ? merged : data_q;
        ack_d    = rden;
        // irq looks ahead at the values being loaded, so a clearing read
        // drops irq in the same cycle ack rises.
        irq_d    = |(status_d & mask_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
        end
    end

    assign data_out = data_q;
    assign ack      = ack_q;
    assign irq      = irq_q;

`ifdef REGISTER_RO_OVERRUN_EN
    logic [WIDTH-1:0] ovr_q, ovr_d;
    logic [WIDTH-1:0] ovr_snap_q, ovr_snap_d;
    logic [WIDTH-1:0] ovr_all;

    always_comb begin
        // A repeat event only counts as overrun if its status bit survives
        // this edge; a bit being cleared by the read is reported, not lost.
        ovr_all    = ovr_q | (set_in & status_q & ~clr_now);
        ovr_d      = ovr_all & ~clr_now;
        ovr_snap_d = rden ? ovr_all : ovr_snap_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q      <= '0;
            ovr_snap_q <= '0;
        end else begin
            ovr_q      <= ovr_d;
            ovr_snap_q <= ovr_snap_d;
        end
    end

    // During the ack cycle present the pre-clear value next to data_out.
    assign overrun = ack_q ? ovr_snap_q : ovr_q;
`endif

endmodule

// File: tb/tb_register_ro.sv
module tb_register_ro;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] set_in;
    logic             rden;
    logic             mask_wren;
    logic [WIDTH-1:0] mask_in;
    logic [WIDTH-1:0] data_out;
    logic             ack;
    logic             irq;
`ifdef REGISTER_RO_OVERRUN_EN
    logic [WIDTH-1:0] overrun;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    register_ro #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_in    (set_in),
        .rden      (rden),
        .mask_wren (mask_wren),
        .mask_in   (mask_in),
        .data_out  (data_out),
        .ack       (ack),
`ifdef REGISTER_RO_OVERRUN_EN
        .overrun   (overrun),
`endif
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        set_in    = 32'hFFFF_FFFF;
        rden      = 1'b1;
        mask_wren = 1'b0;
        mask_in   = '0;

        // Reset: events and reads are ignored while rst=0.
        tick(); tick();
        check("rst_data", data_out, 32'h0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        set_in = '0;
        rden   = 1'b0;
        rst    = 1'b1;
        tick();
        check("rel_ack", {31'd0, ack}, 32'd0);
        check("rel_data", data_out, 32'h0);

        // Only post-release events appear in the first read.
        set_in = 32'hFFFF_FFFF; tick(); set_in = '0;
        rden = 1'b1; tick(); rden = 1'b0;
        check("first_ack", {31'd0, ack}, 32'd1);
        check("first_data", data_out, 32'hFFFF_FFFF);
        tick();
        check("ack_drop", {31'd0, ack}, 32'd0);
        check("data_hold", data_out, 32'hFFFF_FFFF);

        // Sticky + clear-on-read.
        set_in = 32'h5; tick(); set_in = '0;
        tick(); tick(); tick();
        check("sticky_noack", {31'd0, ack}, 32'd0);
        rden = 1'b1; tick(); rden = 1'b0;
        check("sticky_ack", {31'd0, ack}, 32'd1);
        check("sticky_data", data_out, 32'h5);
        tick();
        rden = 1'b1; tick(); rden = 1'b0;
        check("clr_ack", {31'd0, ack}, 32'd1);
        check("clr_data", data_out, 32'h0);
        tick();

        // Same-edge event is in the snapshot, then gone.
        set_in = 32'h8000_0000; rden = 1'b1; tick(); set_in = '0;
        check("same_data", data_out, 32'h8000_0000);
        tick();
        check("same_ack2", {31'd0, ack}, 32'd1);
        check("same_next", data_out, 32'h0);
        rden = 1'b0; tick();

        // Back-to-back reads.
        rden = 1'b1;
        set_in = 32'h1; tick();
        check("b2b_ack0", {31'd0, ack}, 32'd1);
        check("b2b_data0", data_out, 32'h1);
        set_in = 32'h2; tick();
        check("b2b_ack1", {31'd0, ack}, 32'd1);
        check("b2b_data1", data_out, 32'h2);
        set_in = 32'h4; tick();
        check("b2b_ack2", {31'd0, ack}, 32'd1);
        check("b2b_data2", data_out, 32'h4);
        rden = 1'b0; set_in = '0; tick();
        check("b2b_end", {31'd0, ack}, 32'd0);

        // Interrupt masking.
        mask_in = 32'h2; mask_wren = 1'b1; tick(); mask_wren = 1'b0;
        check("irq_mask", {31'd0, irq}, 32'd0);
        set_in = 32'h1; tick(); set_in = '0;
        check("irq_unmasked", {31'd0, irq}, 32'd0);
        set_in = 32'h2; tick(); set_in = '0;
        check("irq_set", {31'd0, irq}, 32'd1);
        rden = 1'b1; tick(); rden = 1'b0;
        check("irq_rd_ack", {31'd0, ack}, 32'd1);
        check("irq_rd_data", data_out, 32'h3);
        check("irq_rd_clr", {31'd0, irq}, 32'd0);
        tick();
        check("irq_stay0", {31'd0, irq}, 32'd0);

        // Simultaneous mask write and read: new mask, post-clear status.
        set_in = 32'h4; tick(); set_in = '0;
        check("sim_pre", {31'd0, irq}, 32'd0);
        mask_in = 32'h4; mask_wren = 1'b1; rden = 1'b1; tick();
        mask_wren = 1'b0; rden = 1'b0;
        check("sim_irq", {31'd0, irq}, 32'd0);
        check("sim_data", data_out, 32'h4);
        set_in = 32'h4; tick(); set_in = '0;
        check("mask4_irq", {31'd0, irq}, 32'd1);
        mask_in = 32'h0; mask_wren = 1'b1; tick(); mask_wren = 1'b0;
        check("mask0_irq", {31'd0, irq}, 32'd0);
        mask_in = 32'h4; mask_wren = 1'b1; tick(); mask_wren = 1'b0;
        check("remask_irq", {31'd0, irq}, 32'd1);
        // Set on the read edge is cleared too.
        set_in = 32'h4; rden = 1'b1; tick(); set_in = '0; rden = 1'b0;
        check("rdset_irq", {31'd0, irq}, 32'd0);
        check("rdset_data", data_out, 32'h4);
        tick();

`ifdef REGISTER_RO_OVERRUN_EN
        set_in = 32'h1; tick();
        check("ovr_first", overrun, 32'h0);
        tick(); set_in = '0;
        check("ovr_set", overrun, 32'h1);
        rden = 1'b1; tick(); rden = 1'b0;
        check("ovr_ack", overrun, 32'h1);
        check("ovr_ackdata", data_out, 32'h1);
        tick();
        check("ovr_clr", overrun, 32'h0);
`endif

        // Reset in the middle of a read suppresses the ack.
        set_in = 32'h10; tick(); set_in = '0;
        rden = 1'b1;
        rst  = 1'b0;
        tick();
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        rden = 1'b0;
        rst  = 1'b1;
        tick();
        check("postrst_ack", {31'd0, ack}, 32'd0);
        rden = 1'b1; tick(); rden = 1'b0;
        check("postrst_data", data_out, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
